// File: rtl/sr_crypto_sha_unit.sv
// Zknh SHA-256/SHA-512(RV32) hash unit: accumulates one XOR term per cycle
// (or all terms at once when FAST=1) and returns the result with a one-cycle strobe.
module sr_crypto_sha_unit #(
    parameter bit FAST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic        o_err
);

    localparam int DATA_W = 32;

    typedef enum logic {IDLE, CALC} state_e;

    state_e              state_q, state_d;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   rs1_q, rs2_q;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [2:0]          k_q, k_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                accept;
    logic                illegal;
    logic                last;
    logic [DATA_W-1:0]   term_k;
    logic [DATA_W-1:0]   final_val;

    function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [2:0] num_terms(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: return 3'd3;
            4'd4, 4'd6:             return 3'd5;
            4'd5, 4'd7, 4'd8, 4'd9: return 3'd6;
            default:                return 3'd1;
        endcase
    endfunction

    // Term k (1-based) of each op, in the order the accumulator consumes them.
    function automatic logic [DATA_W-1:0] term(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b, input logic [2:0] k);
        case (op)
            4'd0: case (k) 3'd1: return ror(a, 7);  3'd2: return ror(a, 18); default: return a >> 3;  endcase
            4'd1: case (k) 3'd1: return ror(a, 17); 3'd2: return ror(a, 19); default: return a >> 10; endcase
            4'd2: case (k) 3'd1: return ror(a, 2);  3'd2: return ror(a, 13); default: return ror(a, 22); endcase
            4'd3: case (k) 3'd1: return ror(a, 6);  3'd2: return ror(a, 11); default: return ror(a, 25); endcase
            4'd4: case (k)
                      3'd1: return a >> 1;  3'd2: return a >> 7; 3'd3: return a >> 8;
                      3'd4: return b << 31; default: return b << 24;
                  endcase
            4'd5: case (k)
                      3'd1: return a >> 1;  3'd2: return a >> 7;  3'd3: return a >> 8;
                      3'd4: return b << 31; 3'd5: return b << 25; default: return b << 24;
                  endcase
            4'd6: case (k)
                      3'd1: return a << 3;  3'd2: return a >> 6; 3'd3: return a >> 19;
                      3'd4: return b >> 29; default: return b << 13;
                  endcase
            4'd7: case (k)
                      3'd1: return a << 3;  3'd2: return a >> 6;  3'd3: return a >> 19;
                      3'd4: return b >> 29; 3'd5: return b << 26; default: return b << 13;
                  endcase
            4'd8: case (k)
                      3'd1: return a << 25; 3'd2: return a << 30; 3'd3: return a >> 28;
                      3'd4: return b >> 7;  3'd5: return b >> 2;  default: return b << 4;
                  endcase
            4'd9: case (k)
                      3'd1: return a << 23; 3'd2: return a >> 14; 3'd3: return a >> 18;
                      3'd4: return b >> 9;  3'd5: return b << 18; default: return b << 14;
                  endcase
            default: return '0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] all_terms(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] x;
        x = '0;
        for (int k = 1; k <= 6; k++) begin
            if (3'(k) <= num_terms(op)) x = x ^ term(op, a, b, 3'(k));
        end
        return x;
    endfunction

    assign accept    = (state_q == IDLE) && i_start && !i_flush;
    assign illegal   = (op_q > 4'd9);
    assign last      = FAST || (k_q == num_terms(op_q));
    assign term_k    = term(op_q, rs1_q, rs2_q, k_q);
    assign final_val = FAST ? all_terms(op_q, rs1_q, rs2_q) : (acc_q ^ term_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Operands are captured only on acceptance; later input changes are invisible.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= i_op;
            rs1_q <= i_rs1;
            rs2_q <= i_rs2;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        k_d      = k_q;
        result_d = result_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    acc_d   = '0;
                    k_d     = 3'd1;
                end
            end
            CALC: begin
                // Flush wins over completion in the same cycle.
                if (i_flush) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    k_d     = '0;
                end else if (illegal) begin
                    state_d  = IDLE;
                    result_d = '0;
                    valid_d  = 1'b1;
                    err_d    = 1'b1;
                    k_d      = '0;
                end else if (last) begin
                    state_d  = IDLE;
                    result_d = final_val;
                    valid_d  = 1'b1;
                    k_d      = '0;
                end else begin
                    acc_d = acc_q ^ term_k;
                    k_d   = k_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready  = (state_q == IDLE);
        o_busy   = (state_q != IDLE);
        o_valid  = valid_q;
        o_err    = err_q;
        o_result = result_q;
    end

endmodule

// File: tb/tb_sr_crypto_sha_unit.sv
// Randomized and directed bench for sr_crypto_sha_unit (FAST=0 and FAST=1 builds)
// against a formula-level reference model.
module tb_sr_crypto_sha_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0, f_start = 1'b0;
    logic [3:0]  i_op = '0;
    logic [31:0] i_rs1 = '0, i_rs2 = '0;
    logic        i_flush = 1'b0;
    logic        o_ready, o_busy, o_valid, o_err;
    logic [31:0] o_result;
    logic        f_ready, f_busy, f_valid, f_err;
    logic [31:0] f_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_crypto_sha_unit #(.FAST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_flush(i_flush), .o_ready(o_ready), .o_busy(o_busy), .o_valid(o_valid),
        .o_result(o_result), .o_err(o_err)
    );

    sr_crypto_sha_unit #(.FAST(1'b1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .i_start(f_start), .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_flush(i_flush), .o_ready(f_ready), .o_busy(f_busy), .o_valid(f_valid),
        .o_result(f_result), .o_err(f_err)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0: return rotr(a, 7) ^ rotr(a, 18) ^ (a >> 3);
            1: return rotr(a, 17) ^ rotr(a, 19) ^ (a >> 10);
            2: return rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            3: return rotr(a, 6) ^ rotr(a, 11) ^ rotr(a, 25);
            4: return (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 24);
            5: return (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 25) ^ (b << 24);
            6: return (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 13);
            7: return (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 26) ^ (b << 13);
            8: return (a << 25) ^ (a << 30) ^ (a >> 28) ^ (b >> 7) ^ (b >> 2) ^ (b << 4);
            9: return (a << 23) ^ (a >> 14) ^ (a >> 18) ^ (b >> 9) ^ (b << 18) ^ (b << 14);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op);
        int lat_tab [16] = '{3, 3, 3, 3, 5, 6, 5, 6, 6, 6, 1, 1, 1, 1, 1, 1};
        return lat_tab[op];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op on the FAST=0 unit and reports what was observed.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic err,
                          output int busy_cyc, output logic held, output logic vld_after);
        logic [31:0] prev;
        prev = o_result;
        i_op = op; i_rs1 = a; i_rs2 = b; i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_op = 4'($urandom); i_rs1 = $urandom; i_rs2 = $urandom;
        lat = -1; busy_cyc = 0; held = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (o_busy === 1'b1) busy_cyc++;
            if (o_result !== prev) held = 1'b0;
            step();
            if (o_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        res = o_result;
        err = o_err;
        step();
        vld_after = o_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({o_ready, o_busy, o_valid, o_err, o_result} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b busy=%b vld=%b err=%b res=%h, want 1 0 0 0 00000000",
                     o_ready, o_busy, o_valid, o_err, o_result);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        n_checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_idle: got rdy=%b vld=%b, want 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [4] = '{4'd0, 4'd2, 4'd1, 4'd5};
        logic [31:0] r1  [4] = '{32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h0};
        logic [31:0] r2  [4] = '{32'h0, 32'h0, 32'h0, 32'h1};
        logic [31:0] exp [4] = '{32'h02004000, 32'h20040200, 32'h003FFFFF, 32'h83000000};
        int          elat[4] = '{3, 3, 3, 6};
        int lat, bc; logic [31:0] res; logic err, held, va;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], r1[i], r2[i], lat, res, err, bc, held, va);
            n_checks++;
            if (lat !== elat[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat[i]); end
            n_checks++;
            if (res !== exp[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, res, exp[i]); end
            n_checks++;
            if (err !== 1'b0) begin n_fail++; $display("FAIL dir%0d_err: got %b want 0", i, err); end
            n_checks++;
            if (bc !== elat[i]) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, elat[i]); end
            n_checks++;
            if (held !== 1'b1) begin n_fail++; $display("FAIL dir%0d_result_held: got %b want 1", i, held); end
            n_checks++;
            if (va !== 1'b0) begin n_fail++; $display("FAIL dir%0d_valid_one_cycle: got %b want 0", i, va); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        i_op = 4'd5; i_rs1 = 32'h0; i_rs2 = 32'h1; i_start = 1'b1;
        step();
        i_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (o_valid === 1'b1) begin lat = c; break; end
        end
        n_checks++;
        if (lat !== 6 || o_result !== 32'h83000000) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d res=%h want lat=6 res=83000000", lat, o_result);
        end
        n_checks++;
        if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_valid: got %b want 1", o_ready); end
        i_op = 4'd0; i_rs1 = 32'h1; i_rs2 = 32'h0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (o_valid === 1'b1) begin lat = c; break; end
        end
        n_checks++;
        if (lat !== 3 || o_result !== 32'h02004000) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d res=%h want lat=3 res=02004000", lat, o_result);
        end
        step();
    endtask

    task automatic test_illegal();
        int lat, bc; logic [31:0] res; logic err, held, va;
        run_op(4'd12, $urandom, $urandom, lat, res, err, bc, held, va);
        n_checks++;
        if (lat !== 1 || res !== 32'h0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_op12: got lat=%0d res=%h err=%b want lat=1 res=00000000 err=1", lat, res, err);
        end
        run_op(4'd0, 32'h1, 32'h0, lat, res, err, bc, held, va);
        n_checks++;
        if (lat !== 3 || res !== 32'h02004000 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_illegal_op0: got lat=%0d res=%h err=%b want lat=3 res=02004000 err=0", lat, res, err);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        int nv;
        prev = o_result;
        i_op = 4'd9; i_rs1 = $urandom; i_rs2 = $urandom; i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        n_checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== prev) begin
            n_fail++;
            $display("FAIL flush_calc: got vld=%b rdy=%b res=%h want 0 1 %h", o_valid, o_ready, o_result, prev);
        end
        nv = 0;
        for (int c = 0; c < 8; c++) begin step(); if (o_valid === 1'b1) nv++; end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL flush_no_valid: got %0d strobes want 0", nv); end
        i_op = 4'd0; i_start = 1'b1; i_flush = 1'b1;
        step();
        i_start = 1'b0; i_flush = 1'b0;
        n_checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drops_start: got rdy=%b busy=%b want 1 0", o_ready, o_busy);
        end
    endtask

    task automatic test_busy_start();
        logic [31:0] a, got;
        int nv;
        a = $urandom;
        i_op = 4'd3; i_rs1 = a; i_start = 1'b1;
        step();
        i_op = 4'd1; i_rs1 = ~a;
        step();
        i_start = 1'b0;
        nv = 0; got = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (o_valid === 1'b1) begin nv++; got = o_result; end
        end
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL busy_start_count: got %0d strobes want 1", nv); end
        n_checks++;
        if (got !== ref_result(4'd3, a, 32'h0)) begin
            n_fail++;
            $display("FAIL busy_start_result: got %h want %h", got, ref_result(4'd3, a, 32'h0));
        end
    endtask

    task automatic test_async_reset();
        int nv;
        i_op = 4'd7; i_rs1 = $urandom; i_rs2 = $urandom; i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_ready, o_busy, o_valid, o_err, o_result} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b busy=%b vld=%b err=%b res=%h, want 1 0 0 0 00000000",
                     o_ready, o_busy, o_valid, o_err, o_result);
        end
        @(negedge clk) rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 8; c++) begin step(); if (o_valid === 1'b1) nv++; end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL async_reset_no_valid: got %0d strobes want 0", nv); end
    endtask

    task automatic test_random();
        int lat, bc; logic [31:0] res, a, b; logic err, held, va;
        logic [3:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            run_op(op, a, b, lat, res, err, bc, held, va);
            n_checks++;
            if (lat !== ref_latency(op) || res !== ref_result(op, a, b) || err !== (op > 4'd9)) begin
                n_fail++;
                $display("FAIL rand%0d_op%0d: got lat=%0d res=%h err=%b want lat=%0d res=%h err=%b", i, op,
                         lat, res, err, ref_latency(op), ref_result(op, a, b), op > 4'd9);
            end
        end
    endtask

    task automatic test_fast();
        int lat; logic [31:0] a, b; logic [3:0] op;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin op = 4'd7; a = 32'h1; b = 32'h1; end
            else begin op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; end
            i_op = op; i_rs1 = a; i_rs2 = b; f_start = 1'b1;
            step();
            f_start = 1'b0;
            lat = -1;
            for (int c = 1; c <= 10; c++) begin
                step();
                if (f_valid === 1'b1) begin lat = c; break; end
            end
            n_checks++;
            if (lat !== 1 || f_result !== ref_result(op, a, b) || f_err !== (op > 4'd9)) begin
                n_fail++;
                $display("FAIL fast%0d_op%0d: got lat=%0d res=%h err=%b want lat=1 res=%h err=%b", i, op,
                         lat, f_result, f_err, ref_result(op, a, b), op > 4'd9);
            end
            if (i == 0) begin
                n_checks++;
                if (f_result !== 32'h04002008) begin
                    n_fail++;
                    $display("FAIL fast_op7_vector: got %h want 04002008", f_result);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_busy_start();
        test_async_reset();
        test_random();
        test_fast();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_crypto_sha_unit.md
Name: sr_crypto_sha_unit

Overview:
- Multi-cycle Zknh hash-function unit, downstream of the crypto decode/FSM in the control path.
- The FSM issues a one-cycle start with op code and rs1/rs2, holds the core on o_busy, and writes back o_result on o_valid.
- Computes one XOR term per cycle into an accumulator, which gives op-dependent latency.
- Covers the SHA256 sig/sum ops and the SHA512 RV32 half ops. AES ops are not handled here; they are flagged as illegal.

Parameters:
- FAST, 0, 1 = all terms XORed in a single cycle (latency 1 for every legal op); 0 = one term per cycle.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_start  in  1  request strobe; accepted only when o_ready=1
- i_op  in  4  operation: 0 sha256sig0, 1 sha256sig1, 2 sha256sum0, 3 sha256sum1, 4 sha512sig0h, 5 sha512sig0l, 6 sha512sig1h, 7 sha512sig1l, 8 sha512sum0r, 9 sha512sum1r, 10-15 illegal
- i_rs1  in  32  operand 1
- i_rs2  in  32  operand 2 (ignored by ops 0-3)
- i_flush  in  1  synchronous abort
- o_ready  out  1  IDLE; a start will be accepted
- o_busy  out  1  ~o_ready; drives core hold
- o_valid  out  1  one-cycle result strobe
- o_result  out  32  result; held until the next accepted start
- o_err  out  1  one-cycle strobe with o_valid for an illegal op

Behaviour:
- Reset (async): state IDLE, acc=0, term counter=0, o_result=0, o_valid=0, o_err=0, o_ready=1.
- States:
  - IDLE: o_ready=1.
  - CALC: o_busy=1.
- Accept (edge E0, IDLE & i_start):
  - Latch op, rs1, rs2; clear acc to 0; set k=1; go to CALC.
  - o_result keeps its old value until completion.
- CALC, edge Ek (k=1..N): acc ^= term_k(op).
  - At k=N: o_result <= acc ^ term_N, o_valid <= 1, state <= IDLE.
  - Latency from accept to o_valid = N cycles; o_valid deasserts at the following edge.
  - o_ready is 1 in the cycle o_valid is high, so back-to-back starts are allowed.
- Terms in order (ror = rotate right; shifts are logical, 32-bit, truncated). N in parentheses:
  - sig0 (3): ror7, ror18, >>3 of rs1
  - sig1 (3): ror17, ror19, >>10
  - sum0 (3): ror2, ror13, ror22
  - sum1 (3): ror6, ror11, ror25
  - sig0h (5): rs1>>1, rs1>>7, rs1>>8, rs2<<31, rs2<<24
  - sig0l (6): rs1>>1, rs1>>7, rs1>>8, rs2<<31, rs2<<25, rs2<<24
  - sig1h (5): rs1<<3, rs1>>6, rs1>>19, rs2>>29, rs2<<13
  - sig1l (6): rs1<<3, rs1>>6, rs1>>19, rs2>>29, rs2<<26, rs2<<13
  - sum0r (6): rs1<<25, rs1<<30, rs1>>28, rs2>>7, rs2>>2, rs2<<4
  - sum1r (6): rs1<<23, rs1>>14, rs1>>18, rs2>>9, rs2<<18, rs2<<14
- Illegal op (10-15): accepted like a legal op.
  - At E1: o_result=0, o_valid=1, o_err=1, back to IDLE.
  - Latency 1, independent of FAST.
- FAST=1: all N terms XORed at E1 (latency 1).
- i_start while busy: ignored; no effect on the operation in flight; the op must be reissued.
- i_flush:
  - In CALC: next edge returns to IDLE, no o_valid, o_result unchanged, acc cleared.
  - Has priority over completion at the same edge.
  - i_flush with i_start in IDLE: the start is dropped.
- Operands are latched at E0; changes to i_rs1/i_rs2/i_op during CALC have no effect.
- rst_n low mid-operation aborts immediately (async); no o_valid after release.

Test Plan:
- op0, rs1=0x00000001, start at E0 -> o_valid only in the cycle after E3, o_result=0x02004000, o_err=0; o_busy high for exactly 3 cycles.
- op2, rs1=0x80000000 -> o_result=0x20040200 at latency 3.
- op1, rs1=0xFFFFFFFF -> 0x003FFFFF.
- op5, rs1=0, rs2=0x1 -> 0x83000000 at latency 6.
- Back-to-back: immediately followed by op0 rs1=1 started in its o_valid cycle -> 0x02004000 three cycles later.
- op12 -> o_valid=o_err=1 at latency 1, o_result=0.
- Next op0 gives o_err=0.
- op9 started, i_flush asserted in cycle 2 -> no o_valid, o_ready=1 next cycle, o_result equals previous value.
- A second i_start during busy is ignored (only one o_valid).
- rst_n pulsed low during op7 -> all outputs 0 immediately, o_ready=1.
- FAST=1 build: op7 rs1=0x1, rs2=0x1 -> latency 1, o_result = 0x8 ^ 0x0 ^ 0x0 ^ 0x0 ^ 0x04000000 ^ 0x00002000 = 0x04002008.
